par_chk_rx: RTL and testbench



---
 rtl/par_chk_rx_pkg.sv | 26 ++
 rtl/par_chk_rx_sync2.sv | 34 +++
 rtl/par_chk_rx.sv | 212 +++++++++++++++++++++
 tb/tb_par_chk_rx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/par_chk_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : par_chk_rx_pkg
//  Description : Shared parity definitions (par_defs) for the parity
//                generator / checker family: FSM state encodings for the
//                serial receiver and the even/odd parity mode constants.
//  Contents    : PAR_EVEN, PAR_ODD, state_t
//  Revision    : 1.0 - initial release
// ============================================================================
package par_chk_rx_pkg;

    // Parity mode selector values, shared with the par_gen benches.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Receiver FSM encoding.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage : par_chk_rx_pkg
`default_nettype wire

// File: rtl/par_chk_rx_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : sync2
//  Description : Generic two-flop synchroniser for a single asynchronous
//                input. Both flops reset to RST_VAL.
//  Ports       : clk  - clock
//                rst  - synchronous active-high reset
//                d    - asynchronous input
//                q    - synchronised output (2 cycles latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule : sync2
`default_nettype wire

// File: rtl/par_chk_rx.sv
`default_nettype none
// ============================================================================
//  Module      : par_chk_rx
//  Description : Serial receive stage with parity check. Deserialises one
//                frame (start, DATA_W data bits LSB first, parity, stop),
//                checks parity against the mode latched at the start bit and
//                presents the payload with a one-cycle valid strobe.
//  Ports       : clk       - clock, rising edge
//                rst       - synchronous active-high reset
//                rx        - serial line, idles high, asynchronous
//                p         - parity mode (0 = even, 1 = odd)
//                data_out  - received payload, bit 0 first on the line
//                valid     - one-cycle strobe, data_out/flags update with it
//                par_err   - parity mismatch of the last frame
//                frame_err - stop bit sampled low on the last frame
//                err_cnt   - saturating error-frame count
//                            (only when PAR_CHK_ERR_CNT_EN is defined)
//  Options     : `define PAR_CHK_ERR_CNT_EN adds the err_cnt output.
//  Revision    : 1.0 - initial release
// ============================================================================
module par_chk_rx
    import par_chk_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              p,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              par_err,
    output logic              frame_err
`ifdef PAR_CHK_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_W + 2);

    localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] END_CNT  = CNT_W'(CLKS_PER_BIT - 1);
    // bit_cnt value while taking the final (parity) sample
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W);

    logic              rx_s;
    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  clk_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W:0]   shreg;      // [DATA_W] = parity, [DATA_W-1:0] = payload
    logic              p_l;
    logic              stop_sample;

    logic              cnt_clr;
    logic              cnt_inc;
    logic              start_ok;
    logic              shift_en;
    logic              stop_en;
    logic              done;
    logic              par_err_nx;

    sync2 #(
        .RST_VAL (1'b1)
    ) u_sync2 (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        start_ok = 1'b0;
        shift_en = 1'b0;
        stop_en  = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (!rx_s) begin
                    state_nx = START;
                end
            end
            START: begin
                if (clk_cnt == MID_CNT) begin
                    cnt_clr = 1'b1;
                    if (rx_s) begin
                        // line back high before mid-point: glitch
                        state_nx = IDLE;
                    end else begin
                        start_ok = 1'b1;
                        state_nx = DATA;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DATA: begin
                if (clk_cnt == END_CNT) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_nx = STOP;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            STOP: begin
                if (clk_cnt == END_CNT) begin
                    cnt_clr  = 1'b1;
                    stop_en  = 1'b1;
                    state_nx = DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counters, shift register and latched frame attributes
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            p_l         <= PAR_EVEN;
            stop_sample <= 1'b1;
        end else begin
            if (cnt_clr) begin
                clk_cnt <= '0;
            end else if (cnt_inc) begin
                clk_cnt <= clk_cnt + CNT_W'(1);
            end
            if (start_ok) begin
                p_l     <= p;
                bit_cnt <= '0;
            end
            if (shift_en) begin
                // LSB arrives first, so shift in at the top
                shreg   <= {rx_s, shreg[DATA_W:1]};
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
            if (stop_en) begin
                stop_sample <= rx_s;
            end
        end
    end

    // XOR over payload+parity is 0 for a good even frame, 1 for a good odd one
    assign par_err_nx = (^shreg) ^ (p_l == PAR_ODD);

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out  <= '0;
            valid     <= 1'b0;
            par_err   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid <= done;
            if (done) begin
                data_out  <= shreg[DATA_W-1:0];
                par_err   <= par_err_nx;
                frame_err <= ~stop_sample;
            end
        end
    end

`ifdef PAR_CHK_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= 8'h00;
        end else if (done && (par_err_nx || !stop_sample) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'h01;
        end
    end
`endif

endmodule : par_chk_rx
`default_nettype wire

// File: tb/tb_par_chk_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_par_chk_rx
//  Description : Self-checking bench for par_chk_rx (CLKS_PER_BIT=4,
//                DATA_W=7). Expected results are queued when a frame is
//                driven and compared when valid is observed.
//                Define PAR_CHK_ERR_CNT_EN to also check err_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_par_chk_rx;

    localparam int CPB = 4;
    localparam int DW  = 7;

    logic          clk;
    logic          rst;
    logic          rx;
    logic          p;
    logic [DW-1:0] data_out;
    logic          valid;
    logic          par_err;
    logic          frame_err;
`ifdef PAR_CHK_ERR_CNT_EN
    logic [7:0]    err_cnt;
    logic [7:0]    exp_err_cnt;
`endif

    par_chk_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_W       (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .p         (p),
        .data_out  (data_out),
        .valid     (valid),
        .par_err   (par_err),
        .frame_err (frame_err)
`ifdef PAR_CHK_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          parity;
        logic          stop;
        logic          p0;
        logic          flip;
        logic [DW-1:0] e_data;
        logic          e_perr;
        logic          e_ferr;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          perr;
        logic          ferr;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];
    exp_t last;
    int   checks;
    int   errors;
    int   nvalid;
    int   npushed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // One clock; outputs sampled 1ns after the edge and valid scoreboarded.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (valid === 1'b1) begin
            nvalid++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got valid=1 data_out=%h, required no valid", data_out);
            end else begin
                e = sb.pop_front();
                check("data_out", 32'(data_out), 32'(e.data));
                check("par_err", 32'(par_err), 32'(e.perr));
                check("frame_err", 32'(frame_err), 32'(e.ferr));
`ifdef PAR_CHK_ERR_CNT_EN
                if ((e.perr || e.ferr) && exp_err_cnt != 8'hFF) exp_err_cnt++;
                check("err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
`endif
                last = e;
            end
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) tick();
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input logic pe, input logic fe);
        exp_t e;
        e.data = d;
        e.perr = pe;
        e.ferr = fe;
        sb.push_back(e);
        npushed++;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic stp,
                              input logic p0, input logic flip);
        p = p0;
        send_bit(1'b0);
        for (int i = 0; i < DW; i++) begin
            if (flip && i == 3) p = ~p0;
            send_bit(d[i]);
        end
        send_bit(par);
        send_bit(stp);
        send_bit(1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout: got %0d pending frames, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_out"}, 32'(data_out), 32'h0);
        check({tag, "_valid"}, 32'(valid), 32'h0);
        check({tag, "_par_err"}, 32'(par_err), 32'h0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
`ifdef PAR_CHK_ERR_CNT_EN
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'h0);
`endif
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        nvalid  = 0;
        npushed = 0;
        last    = '{default: '0};
`ifdef PAR_CHK_ERR_CNT_EN
        exp_err_cnt = 8'h00;
`endif
        //           data   par   stop  p     flip  e_data e_perr e_ferr
        vecs[0] = '{7'h55, 1'b0, 1'b1, 1'b0, 1'b0, 7'h55, 1'b0, 1'b0}; // even ok
        vecs[1] = '{7'h55, 1'b1, 1'b1, 1'b0, 1'b0, 7'h55, 1'b1, 1'b0}; // even bad parity
        vecs[2] = '{7'h00, 1'b1, 1'b1, 1'b1, 1'b1, 7'h00, 1'b0, 1'b0}; // odd, p flipped mid-frame
        vecs[3] = '{7'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 7'h7F, 1'b0, 1'b1}; // bad stop bit
        vecs[4] = '{7'h00, 1'b0, 1'b1, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0}; // odd bad parity
        vecs[5] = '{7'h01, 1'b0, 1'b1, 1'b1, 1'b0, 7'h01, 1'b0, 1'b0}; // odd ok

        rst = 1'b1;
        rx  = 1'b1;
        p   = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        tick();
        check_reset_outputs("reset");

        for (int v = 0; v < 6; v++) begin
            push_exp(vecs[v].e_data, vecs[v].e_perr, vecs[v].e_ferr);
            send_frame(vecs[v].data, vecs[v].parity, vecs[v].stop, vecs[v].p0, vecs[v].flip);
            drain();
        end

        // Start-bit glitch shorter than the mid-point: no frame, outputs hold.
        rx = 1'b0;
        tick();
        rx = 1'b1;
        repeat (20) tick();
        check("glitch_data_out", 32'(data_out), 32'(last.data));
        check("glitch_par_err", 32'(par_err), 32'(last.perr));
        check("glitch_frame_err", 32'(frame_err), 32'(last.ferr));

        // Reset during DATA bit 3 of a 7'h55 frame: partial frame discarded.
        p = 1'b0;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rx = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
`ifdef PAR_CHK_ERR_CNT_EN
        exp_err_cnt = 8'h00;
`endif
        rst = 1'b0;
        rx  = 1'b1;
        repeat (12 * CPB) tick();
        push_exp(7'h2A, 1'b0, 1'b0);
        send_frame(7'h2A, 1'b1, 1'b1, 1'b0, 1'b0);
        drain();
        repeat (10) tick();

        check("valid_count", 32'(nvalid), 32'(npushed));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_par_chk_rx
`default_nettype wire
